// File: rtl/kernel_pkg.sv
// Constants shared by the Kernel, the output quantizer and the frame writer.
package kernel_pkg;

  localparam int PIX_W          = 8;
  localparam int MAC_W          = 32;
  localparam int SHIFT_DEF      = 4;
  localparam int SKIP_DEF       = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/kernel_sync_fifo.sv
// Small synchronous FIFO.
// Head is forced to zero while empty.
module kernel_sync_fifo
  import kernel_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/kernel_out_quantizer.sv
// Samples the Kernel MAC once per slow period, rounds, shifts, clamps to a pixel
// and queues the result toward the frame writer.
module kernel_out_quantizer
  import kernel_pkg::*;
#(
  parameter int IN_W       = MAC_W,
  parameter int OUT_W      = PIX_W,
  parameter int SHIFT      = SHIFT_DEF,
  parameter int SKIP       = SKIP_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             slow_clk_in,
  input  logic [IN_W-1:0]  z_in,
  output logic [OUT_W-1:0] pix_out,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             sat_flag,
  output logic             ovf_flag,
  output logic [CNT_W-1:0] pix_count
);

  localparam int SK_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SK_W-1:0] SKIP_C = SK_W'(SKIP);
  localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_W:0] HALF =
    (SHIFT > 0) ? ((IN_W+1)'(1) << HS) : '0;
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << OUT_W) - 1);

  logic              s0_q, s1_q;
  logic              sample_en;
  logic              v1_q, v1_d;
  logic [IN_W-1:0]   z_q, z_d;
  logic              v2_q, v2_d;
  logic [OUT_W-1:0]  q_q, q_d;
  logic              cl_q, cl_d;
  logic [SK_W-1:0]   skip_q, skip_d;
  logic              sat_q, sat_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic signed [IN_W:0] z_ext;
  logic signed [IN_W:0] r;
  logic [OUT_W-1:0]     q_new;
  logic                 cl_new;
  logic                 skip_done;
  logic                 push_req;
  logic                 push_ok;
  logic                 pop;
  logic                 full;
  logic                 empty;

  assign sample_en = s0_q & ~s1_q;
  assign skip_done = (skip_q == SKIP_C);
  assign push_req  = v2_q & skip_done;
  assign pop       = pix_valid & pix_ready;
  assign push_ok   = push_req & (~full | pop);

  // One extra bit keeps the rounding add from wrapping near +max.
  always_comb begin
    z_ext  = {z_q[IN_W-1], z_q};
    r      = (z_ext + HALF) >>> SHIFT;
    q_new  = r[OUT_W-1:0];
    cl_new = 1'b0;
    if (r < 0) begin
      q_new  = '0;
      cl_new = 1'b1;
    end else if (r > MAXV) begin
      q_new  = '1;
      cl_new = 1'b1;
    end
  end

  always_comb begin
    z_d    = z_q;
    q_d    = q_q;
    cl_d   = cl_q;
    v1_d   = sample_en;
    v2_d   = v1_q;
    skip_d = skip_q;
    sat_d  = sat_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    if (sample_en) z_d = z_in;
    if (v1_q) begin
      q_d  = q_new;
      cl_d = cl_new;
    end
    if (v2_q && !skip_done) skip_d = skip_q + 1'b1;
    if (push_req && cl_q)   sat_d  = 1'b1;
    if (push_req && !push_ok) ovf_d = 1'b1;
    if (push_ok) cnt_d = cnt_q + 1'b1;
    if (clr) begin
      v1_d   = 1'b0;
      v2_d   = 1'b0;
      skip_d = '0;
      sat_d  = 1'b0;
      ovf_d  = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      v1_q   <= 1'b0;
      z_q    <= '0;
      v2_q   <= 1'b0;
      q_q    <= '0;
      cl_q   <= 1'b0;
      skip_q <= '0;
      sat_q  <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s0_q   <= slow_clk_in;
      s1_q   <= s0_q;
      v1_q   <= v1_d;
      z_q    <= z_d;
      v2_q   <= v2_d;
      q_q    <= q_d;
      cl_q   <= cl_d;
      skip_q <= skip_d;
      sat_q  <= sat_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  kernel_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push_ok),
    .pop   (pop),
    .wdata (q_q),
    .rdata (pix_out),
    .full  (full),
    .empty (empty)
  );

  assign pix_valid = ~empty;
  assign sat_flag  = sat_q;
  assign ovf_flag  = ovf_q;
  assign pix_count = cnt_q;

endmodule

// File: tb/tb_kernel_out_quantizer.sv
// Self-checking bench for kernel_out_quantizer with an arithmetic reference model.
module tb_kernel_out_quantizer;
  import kernel_pkg::*;

  localparam int SHIFT = SHIFT_DEF;
  localparam int SKIP  = SKIP_DEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        slow;
  logic [31:0] z_in;
  logic [7:0]  pix_out;
  logic        pix_valid;
  logic        pix_ready;
  logic        sat_flag;
  logic        ovf_flag;
  logic [15:0] pix_count;

  int n_checks = 0;
  int n_fail   = 0;
  int obs[$];

  kernel_out_quantizer dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .slow_clk_in (slow),
    .z_in        (z_in),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .sat_flag    (sat_flag),
    .ovf_flag    (ovf_flag),
    .pix_count   (pix_count)
  );

  always #5 clk = ~clk;

  // Record every handshake (pop) away from the active edge.
  always @(negedge clk)
    if (!rst && !clr && pix_valid && pix_ready)
      obs.push_back(int'(pix_out));

  function automatic int quant(input longint z, output bit sat);
    longint d, t, r;
    d = longint'(1) << SHIFT;
    t = z + ((SHIFT > 0) ? d / 2 : 0);
    if (t >= 0) r = t / d;
    else        r = -((-t + d - 1) / d);
    sat = (r < 0) || (r > 255);
    if (r < 0)   return 0;
    if (r > 255) return 255;
    return int'(r);
  endfunction

  task automatic slow_period(input logic [31:0] z);
    z_in = z;
    slow = 1'b1;
    repeat (3) @(posedge clk);
    #1 slow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    obs.delete();
  endtask

  task automatic run_skip();
    for (int i = 0; i < SKIP; i++) slow_period(32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; slow = 1'b0; z_in = '0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
    n_checks++;
    if (pix_out !== 8'd0) begin n_fail++; $display("FAIL reset_pix: got %0d expected 0", pix_out); end
    n_checks++;
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", sat_flag); end
    n_checks++;
    if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_flag); end
    n_checks++;
    if (pix_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", pix_count); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_skip();
    int got;
    do_clr();
    pix_ready = 1'b1;
    for (int i = 0; i < 12; i++) slow_period(32'(16 * i));
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs.size() != 4) begin n_fail++; $display("FAIL skip_n: got %0d expected 4", obs.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < obs.size()) ? obs[k] : -1;
      n_checks++;
      if (got != 8 + k) begin n_fail++; $display("FAIL skip_pix[%0d]: got %0d expected %0d", k, got, 8 + k); end
    end
    n_checks++;
    if (pix_count !== 16'd4) begin n_fail++; $display("FAIL skip_count: got %0d expected 4", pix_count); end
  endtask

  task automatic test_rounding();
    int zs[4]  = '{24, 23, 8, 7};
    int exp[4] = '{2, 1, 1, 0};
    int got;
    obs.delete();
    for (int i = 0; i < 4; i++) slow_period(32'(zs[i]));
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      got = (k < obs.size()) ? obs[k] : -1;
      n_checks++;
      if (got != exp[k]) begin n_fail++; $display("FAIL round[%0d]: z=%0d got %0d expected %0d", k, zs[k], got, exp[k]); end
    end
    n_checks++;
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL round_sat: got %b expected 0", sat_flag); end
  endtask

  task automatic test_clamp();
    logic [31:0] zs[3] = '{32'd4096, -32'sd24, 32'h7FFF_FFFF};
    int exp[3] = '{255, 0, 255};
    int got;
    obs.delete();
    slow_period(zs[0]);
    n_checks++;
    if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL clamp_sat: got %b expected 1", sat_flag); end
    slow_period(zs[1]);
    slow_period(zs[2]);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      got = (k < obs.size()) ? obs[k] : -1;
      n_checks++;
      if (got != exp[k]) begin n_fail++; $display("FAIL clamp[%0d]: got %0d expected %0d", k, got, exp[k]); end
    end
    n_checks++;
    if (pix_count !== 16'd11) begin n_fail++; $display("FAIL clamp_count: got %0d expected 11", pix_count); end
  endtask

  task automatic test_backpressure();
    int got;
    do_clr();
    pix_ready = 1'b1;
    run_skip();
    pix_ready = 1'b0;
    for (int k = 0; k < 6; k++) slow_period(32'(16 * (10 + k)));
    n_checks++;
    if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b expected 1", ovf_flag); end
    n_checks++;
    if (pix_count !== 16'd4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", pix_count); end
    n_checks++;
    if (pix_out !== 8'd10 || pix_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_head: got %0d/%b expected 10/1", pix_out, pix_valid);
    end
    pix_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (obs.size() != 4) begin n_fail++; $display("FAIL bp_n: got %0d expected 4", obs.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < obs.size()) ? obs[k] : -1;
      n_checks++;
      if (got != 10 + k) begin n_fail++; $display("FAIL bp_order[%0d]: got %0d expected %0d", k, got, 10 + k); end
    end
    n_checks++;
    if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", pix_valid); end
  endtask

  task automatic test_full_pop_push();
    do_clr();
    pix_ready = 1'b1;
    run_skip();
    pix_ready = 1'b0;
    for (int k = 0; k < 4; k++) slow_period(32'(16 * (20 + k)));
    z_in = 32'(16 * 24);
    slow = 1'b1;
    repeat (3) @(posedge clk);
    #1 slow = 1'b0; pix_ready = 1'b1;
    @(posedge clk);
    #1 pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs.size() != 1 || obs[0] != 20) begin
      n_fail++; $display("FAIL fpp_pop: got n=%0d expected one pop of 20", obs.size());
    end
    n_checks++;
    if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b expected 0", ovf_flag); end
    n_checks++;
    if (pix_count !== 16'd5) begin n_fail++; $display("FAIL fpp_count: got %0d expected 5", pix_count); end
    n_checks++;
    if (pix_out !== 8'd21) begin n_fail++; $display("FAIL fpp_head: got %0d expected 21", pix_out); end
    do_clr();
    n_checks++;
    if (pix_valid !== 1'b0 || pix_count !== 16'd0) begin
      n_fail++; $display("FAIL fpp_clr: got valid=%b count=%0d expected 0/0", pix_valid, pix_count);
    end
  endtask

  task automatic test_latency();
    int n = 0;
    do_clr();
    pix_ready = 1'b0;
    run_skip();
    z_in = 32'(16 * 7);
    slow = 1'b1;
    @(posedge clk);
    while (n < 10) begin
      @(posedge clk);
      n++;
      #1;
      if (pix_valid) break;
    end
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL latency: got %0d edges expected 3", n); end
    slow = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs.size() != 1 || obs[0] != 7) begin
      n_fail++; $display("FAIL latency_pix: got n=%0d expected one pixel of 7", obs.size());
    end
  endtask

  task automatic test_random();
    int exp[$];
    bit sat_exp = 1'b0;
    bit s;
    logic [31:0] z;
    int got;
    int v;
    do_clr();
    pix_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: z = 32'($urandom_range(0, 4095));
        1: z = -32'($urandom_range(1, 300));
        2: z = $urandom();
        default: z = 32'($urandom_range(4070, 4110));
      endcase
      slow_period(z);
      if (i >= SKIP) begin
        v = quant(longint'($signed(z)), s);
        exp.push_back(v);
        sat_exp |= s;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs.size() != exp.size()) begin
      n_fail++; $display("FAIL rnd_n: got %0d expected %0d", obs.size(), exp.size());
    end
    for (int k = 0; k < exp.size(); k++) begin
      got = (k < obs.size()) ? obs[k] : -1;
      n_checks++;
      if (got != exp[k]) begin n_fail++; $display("FAIL rnd[%0d]: got %0d expected %0d", k, got, exp[k]); end
    end
    n_checks++;
    if (sat_flag !== sat_exp) begin n_fail++; $display("FAIL rnd_sat: got %b expected %b", sat_flag, sat_exp); end
    n_checks++;
    if (pix_count !== 16'(exp.size())) begin
      n_fail++; $display("FAIL rnd_count: got %0d expected %0d", pix_count, exp.size());
    end
  endtask

  task automatic test_reset_midstream();
    do_clr();
    pix_ready = 1'b0;
    run_skip();
    slow_period(32'd4096);
    for (int k = 0; k < 5; k++) slow_period(32'(16 * k));
    n_checks++;
    if (!(pix_valid && sat_flag && ovf_flag)) begin
      n_fail++; $display("FAIL mid_pre: got v=%b s=%b o=%b expected 1/1/1", pix_valid, sat_flag, ovf_flag);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (pix_valid !== 1'b0 || pix_out !== 8'd0) begin
      n_fail++; $display("FAIL mid_rst_out: got v=%b pix=%0d expected 0/0", pix_valid, pix_out);
    end
    n_checks++;
    if (sat_flag !== 1'b0 || ovf_flag !== 1'b0 || pix_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_rst_flags: got s=%b o=%b c=%0d expected 0/0/0", sat_flag, ovf_flag, pix_count);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_skip();
    test_rounding();
    test_clamp();
    test_backpressure();
    test_full_pop_push();
    test_latency();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
